// File: rtl/cache_miss_sequencer.sv
// rtl/cache_miss_sequencer.sv - miss sequencer driving the pseudo-LRU port, victim lookup, writeback and fill
// Hit-side MRU updates share the LRU port with the miss sequence, one per cycle.
module cache_miss_sequencer #(
  parameter int SET_INDEX_WIDTH = 5,
  parameter int TAG_WIDTH       = 21
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [SET_INDEX_WIDTH-1:0] miss_set,
  input  logic [TAG_WIDTH-1:0]       miss_tag,
  output logic                       miss_done,
  output logic [1:0]                 miss_way,
  input  logic                       hit_valid,
  output logic                       hit_ready,
  input  logic [SET_INDEX_WIDTH-1:0] hit_set,
  input  logic [1:0]                 hit_way,
  output logic                       lru_access,
  output logic [SET_INDEX_WIDTH-1:0] lru_set,
  output logic                       lru_update_mru,
  output logic [1:0]                 lru_new_mru_way,
  input  logic [1:0]                 lru_way,
  output logic [SET_INDEX_WIDTH-1:0] tag_rd_set,
  output logic [1:0]                 tag_rd_way,
  input  logic                       victim_valid,
  input  logic                       victim_dirty,
  input  logic [TAG_WIDTH-1:0]       victim_tag,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [SET_INDEX_WIDTH-1:0] wb_set,
  output logic [1:0]                 wb_way,
  output logic [TAG_WIDTH-1:0]       wb_tag,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [SET_INDEX_WIDTH-1:0] fill_set,
  output logic [1:0]                 fill_way,
  output logic [TAG_WIDTH-1:0]       fill_tag,
  input  logic                       fill_done
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LRU_RD    = 4'd1;
  localparam logic [3:0] TAG_RD    = 4'd2;
  localparam logic [3:0] CHECK     = 4'd3;
  localparam logic [3:0] WB        = 4'd4;
  localparam logic [3:0] FILL      = 4'd5;
  localparam logic [3:0] FILL_WAIT = 4'd6;
  localparam logic [3:0] MRU_SET   = 4'd7;
  localparam logic [3:0] MRU_UPD   = 4'd8;

  logic [3:0]                 state;
  logic [3:0]                 state_nxt;
  logic [SET_INDEX_WIDTH-1:0] m_set;
  logic [TAG_WIDTH-1:0]       m_tag;
  logic [TAG_WIDTH-1:0]       v_tag;
  logic [1:0]                 v_way;
  logic [1:0]                 hit_way_q;
  logic                       hit_pend;
  logic                       hit_window;
  logic                       hit_acc;
  logic                       miss_acc;
  logic                       miss_owns;

  // Blocking hits in the fill_done cycle keeps MRU_SET from reading bits an update is still writing.
  assign hit_window = (state == IDLE) || (state == CHECK) || (state == WB) ||
                      (state == FILL) || (state == FILL_WAIT);
  assign hit_ready  = hit_window && !fill_done;
  assign hit_acc    = hit_valid && hit_ready;

  assign miss_ready = (state == IDLE) && !hit_valid && !hit_pend;
  assign miss_acc   = miss_valid && miss_ready;

  assign miss_owns       = (state == LRU_RD) || (state == MRU_SET);
  assign lru_access      = miss_owns || hit_acc;
  assign lru_set         = miss_owns ? m_set : hit_set;
  assign lru_update_mru  = (state == MRU_UPD) || hit_pend;
  assign lru_new_mru_way = (state == MRU_UPD) ? v_way : hit_way_q;

  // The victim way is only latched at the end of TAG_RD, so the lookup uses lru_way directly.
  assign tag_rd_set = m_set;
  assign tag_rd_way = (state == TAG_RD) ? lru_way : v_way;

  assign wb_valid   = (state == WB);
  assign wb_set     = m_set;
  assign wb_way     = v_way;
  assign wb_tag     = v_tag;

  assign fill_valid = (state == FILL);
  assign fill_set   = m_set;
  assign fill_way   = v_way;
  assign fill_tag   = m_tag;

  assign miss_done  = (state == MRU_UPD);
  assign miss_way   = v_way;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss_acc) state_nxt = LRU_RD;
      LRU_RD:    state_nxt = TAG_RD;
      TAG_RD:    state_nxt = CHECK;
      CHECK:     state_nxt = (victim_valid && victim_dirty) ? WB : FILL;
      WB:        if (wb_ready) state_nxt = FILL;
      FILL:      if (fill_ready) state_nxt = FILL_WAIT;
      FILL_WAIT: if (fill_done) state_nxt = MRU_SET;
      MRU_SET:   state_nxt = MRU_UPD;
      MRU_UPD:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m_set     <= '0;
      m_tag     <= '0;
      v_tag     <= '0;
      v_way     <= '0;
      hit_way_q <= '0;
      hit_pend  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hit_pend <= hit_acc;
      if (hit_acc) hit_way_q <= hit_way;
      if (miss_acc) begin
        m_set <= miss_set;
        m_tag <= miss_tag;
      end
      if (state == TAG_RD) v_way <= lru_way;
      if ((state == CHECK) && victim_valid && victim_dirty) v_tag <= victim_tag;
    end
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// tb/tb_cache_miss_sequencer.sv - scoreboard bench for cache_miss_sequencer
// Directed stimulus pushes expected port events; a negedge monitor pops and compares them.
module tb_cache_miss_sequencer;

  logic        clk;
  logic        reset_n;
  logic        miss_valid, miss_ready;
  logic [4:0]  miss_set;
  logic [20:0] miss_tag;
  logic        miss_done;
  logic [1:0]  miss_way;
  logic        hit_valid, hit_ready;
  logic [4:0]  hit_set;
  logic [1:0]  hit_way;
  logic        lru_access;
  logic [4:0]  lru_set;
  logic        lru_update_mru;
  logic [1:0]  lru_new_mru_way;
  logic [1:0]  lru_way;
  logic [4:0]  tag_rd_set;
  logic [1:0]  tag_rd_way;
  logic        victim_valid, victim_dirty;
  logic [20:0] victim_tag;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_set;
  logic [1:0]  wb_way;
  logic [20:0] wb_tag;
  logic        fill_valid, fill_ready;
  logic [4:0]  fill_set;
  logic [1:0]  fill_way;
  logic [20:0] fill_tag;
  logic        fill_done;

  cache_miss_sequencer #(.SET_INDEX_WIDTH(5), .TAG_WIDTH(21)) dut (
    .clk(clk), .reset_n(reset_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set), .miss_tag(miss_tag),
    .miss_done(miss_done), .miss_way(miss_way),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
    .lru_access(lru_access), .lru_set(lru_set), .lru_update_mru(lru_update_mru),
    .lru_new_mru_way(lru_new_mru_way), .lru_way(lru_way),
    .tag_rd_set(tag_rd_set), .tag_rd_way(tag_rd_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way), .wb_tag(wb_tag),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_done(fill_done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  q_acc[$];
  logic [1:0]  q_upd[$];
  logic [1:0]  q_done[$];
  logic [27:0] q_wb[$];
  logic [27:0] q_fill[$];
  logic [31:0] mon_exp;

  logic [4:0] hs [3] = '{5'd1, 5'd2, 5'd3};
  logic [1:0] hw [3] = '{2'd0, 2'd1, 2'd3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen, expected none", nm);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (lru_access) begin
        if (q_acc.size() == 0) unexpected("lru_access");
        else begin mon_exp = 32'(q_acc.pop_front()); check("lru_set", 32'(lru_set), mon_exp); end
      end
      if (lru_update_mru) begin
        if (q_upd.size() == 0) unexpected("lru_update_mru");
        else begin mon_exp = 32'(q_upd.pop_front()); check("lru_new_mru_way", 32'(lru_new_mru_way), mon_exp); end
      end
      if (miss_done) begin
        if (q_done.size() == 0) unexpected("miss_done");
        else begin mon_exp = 32'(q_done.pop_front()); check("miss_way", 32'(miss_way), mon_exp); end
      end
      if (wb_valid && wb_ready) begin
        if (q_wb.size() == 0) unexpected("wb handshake");
        else begin mon_exp = 32'(q_wb.pop_front()); check("wb set/way/tag", 32'({wb_set, wb_way, wb_tag}), mon_exp); end
      end
      if (fill_valid && fill_ready) begin
        if (q_fill.size() == 0) unexpected("fill handshake");
        else begin mon_exp = 32'(q_fill.pop_front()); check("fill set/way/tag", 32'({fill_set, fill_way, fill_tag}), mon_exp); end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a miss and walks it to the TAG_RD cycle, checking the victim lookup there.
  task automatic start_miss(input logic [4:0] s, input logic [20:0] t, input logic [1:0] lw);
    lru_way = lw; miss_valid = 1'b1; miss_set = s; miss_tag = t;
    #1;
    check("miss_ready at accept", 32'(miss_ready), 1);
    q_acc.push_back(s);
    step();
    miss_valid = 1'b0;
    step();
    check("tag_rd_set", 32'(tag_rd_set), 32'(s));
    check("tag_rd_way", 32'(tag_rd_way), 32'(lw));
  endtask

  task automatic finish_miss(input logic [4:0] s, input logic [20:0] t, input logic [1:0] w);
    for (int i = 0; i < 20 && !fill_valid; i++) step();
    check("fill_valid reached", 32'(fill_valid), 1);
    fill_ready = 1'b1;
    q_fill.push_back({s, w, t});
    step();
    fill_ready = 1'b0;
    step();
    step();
    q_acc.push_back(s); q_upd.push_back(w); q_done.push_back(w);
    fill_done = 1'b1;
    #1;
    check("hit_ready in fill_done cycle", 32'(hit_ready), 0);
    step();
    fill_done = 1'b0;
    step();
    check("miss_done pulse", 32'(miss_done), 1);
    step();
    check("miss_done cleared", 32'(miss_done), 0);
    check("miss_ready back in IDLE", 32'(miss_ready), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    miss_valid = 0; miss_set = 0; miss_tag = 0;
    hit_valid = 0; hit_set = 0; hit_way = 0;
    lru_way = 0; victim_valid = 0; victim_dirty = 0; victim_tag = 0;
    wb_ready = 0; fill_ready = 0; fill_done = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset wb_valid", 32'(wb_valid), 0);
    check("reset fill_valid", 32'(fill_valid), 0);
    check("reset miss_done", 32'(miss_done), 0);
    check("reset lru_update_mru", 32'(lru_update_mru), 0);
    check("reset lru_access", 32'(lru_access), 0);
    reset_n = 1'b1;
    #1;
    check("idle miss_ready", 32'(miss_ready), 1);
    check("idle hit_ready", 32'(hit_ready), 1);
    step();

    // Clean miss: invalid victim, no writeback
    start_miss(5'd5, 21'h01234, 2'd2);
    finish_miss(5'd5, 21'h01234, 2'd2);

    // Dirty victim with writeback backpressure
    victim_valid = 1; victim_dirty = 1; victim_tag = 21'h00ABC;
    start_miss(5'd9, 21'h05555, 2'd3);
    for (int i = 0; i < 10 && !wb_valid; i++) step();
    for (int i = 0; i < 4; i++) begin
      check("wb_valid held", 32'(wb_valid), 1);
      check("wb_set stable", 32'(wb_set), 9);
      check("wb_way stable", 32'(wb_way), 3);
      check("wb_tag stable", 32'(wb_tag), 32'h00ABC);
      check("no fill before wb", 32'(fill_valid), 0);
      step();
    end
    wb_ready = 1'b1;
    q_wb.push_back({5'd9, 2'd3, 21'h00ABC});
    step();
    wb_ready = 1'b0;
    finish_miss(5'd9, 21'h05555, 2'd3);
    victim_valid = 0; victim_dirty = 0;

    // Back-to-back hit stream
    for (int i = 0; i < 3; i++) begin
      hit_valid = 1'b1; hit_set = hs[i]; hit_way = hw[i];
      #1;
      check("hit_ready stream", 32'(hit_ready), 1);
      q_acc.push_back(hs[i]); q_upd.push_back(hw[i]);
      step();
    end
    hit_valid = 1'b0;
    check("last hit update", 32'(lru_update_mru), 1);
    check("last hit way", 32'(lru_new_mru_way), 3);
    step();
    check("hit stream drained", 32'(lru_update_mru), 0);

    // Simultaneous miss and hit in IDLE: hit wins, miss waits out hit_pend
    miss_valid = 1'b1; miss_set = 5'd3; miss_tag = 21'h00777;
    hit_valid = 1'b1; hit_set = 5'd4; hit_way = 2'd2;
    #1;
    check("hit wins in IDLE", 32'(hit_ready), 1);
    check("miss blocked by hit", 32'(miss_ready), 0);
    q_acc.push_back(5'd4); q_upd.push_back(2'd2);
    step();
    hit_valid = 1'b0;
    #1;
    check("miss blocked by hit_pend", 32'(miss_ready), 0);
    step();
    start_miss(5'd3, 21'h00777, 2'd0);
    finish_miss(5'd3, 21'h00777, 2'd0);

    // Hits around a fill: accepted in FILL_WAIT, refused in fill_done through MRU_UPD
    victim_valid = 1; victim_dirty = 0;
    start_miss(5'd12, 21'h0F0F0, 2'd1);
    for (int i = 0; i < 10 && !fill_valid; i++) step();
    check("fill_valid reached", 32'(fill_valid), 1);
    fill_ready = 1'b1;
    q_fill.push_back({5'd12, 2'd1, 21'h0F0F0});
    step();
    fill_ready = 1'b0;
    hit_valid = 1'b1; hit_set = 5'd7; hit_way = 2'd1;
    #1;
    check("hit_ready in FILL_WAIT", 32'(hit_ready), 1);
    q_acc.push_back(5'd7); q_upd.push_back(2'd1);
    step();
    hit_valid = 1'b0;
    step();
    hit_valid = 1'b1; hit_set = 5'd20; hit_way = 2'd2;
    fill_done = 1'b1;
    q_acc.push_back(5'd12); q_upd.push_back(2'd1); q_done.push_back(2'd1);
    #1;
    check("hit refused on fill_done", 32'(hit_ready), 0);
    step();
    fill_done = 1'b0;
    check("hit refused in MRU_SET", 32'(hit_ready), 0);
    step();
    check("hit refused in MRU_UPD", 32'(hit_ready), 0);
    check("miss_done with pending hit", 32'(miss_done), 1);
    step();
    check("hit accepted after MRU_UPD", 32'(hit_ready), 1);
    check("miss_ready low with hit", 32'(miss_ready), 0);
    q_acc.push_back(5'd20); q_upd.push_back(2'd2);
    step();
    hit_valid = 1'b0;
    step();
    check("miss_ready after late hit", 32'(miss_ready), 1);

    // Asynchronous reset while in WB abandons the miss
    victim_valid = 1; victim_dirty = 1; victim_tag = 21'h00100;
    start_miss(5'd30, 21'h1FFFFF, 2'd0);
    for (int i = 0; i < 10 && !wb_valid; i++) step();
    check("wb_valid before reset", 32'(wb_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("wb_valid drops async", 32'(wb_valid), 0);
    check("lru_update_mru in reset", 32'(lru_update_mru), 0);
    step();
    step();
    reset_n = 1'b1;
    wb_ready = 1'b1; fill_ready = 1'b1;
    #1;
    check("miss_ready after reset", 32'(miss_ready), 1);
    for (int i = 0; i < 5; i++) begin
      check("no fill after reset", 32'(fill_valid), 0);
      step();
    end
    wb_ready = 1'b0; fill_ready = 1'b0;
    victim_valid = 0; victim_dirty = 0;
    step();

    check("lru_access queue drained", 32'(q_acc.size()), 0);
    check("update queue drained", 32'(q_upd.size()), 0);
    check("done queue drained", 32'(q_done.size()), 0);
    check("wb queue drained", 32'(q_wb.size()), 0);
    check("fill queue drained", 32'(q_fill.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
